// File: rtl/fifo_sync_flagged.sv
// rtl/fifo_sync_flagged.sv - single-clock FIFO with FWFT option, threshold flags and sticky errors
module fifo_sync_flagged #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic [AW:0]           af_thresh,
    input  logic [AW:0]           ae_thresh,
    output logic [AW:0]           count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_acc, rd_acc;

    // Flags come only from the registered count, so they lag the accepting edge by one cycle.
    assign full         = (count_q == FULL_COUNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = wr_en & ~full  & ~clear;
    assign rd_acc = rd_en & ~empty & ~clear;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
            overflow_d  = overflow_q  | (wr_en & full);
            underflow_d = underflow_q | (rd_en & empty);
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    if (FWFT == 0) begin : g_reg_read
        logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
        logic                  rd_valid_q, rd_valid_d;

        always_comb begin
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
            if (rd_acc) begin
                rd_data_d  = mem_q[rd_ptr_q];
                rd_valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset_b) begin
            if (!reset_b) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end else begin : g_fwft_read
        assign rd_data  = mem_q[rd_ptr_q];
        assign rd_valid = ~empty;
    end

endmodule
